counter_7seg_param: RTL and testbench
=====================================

COUNTER_7SEG_PARAM -- requirements
Module: counter_7seg_param

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD digits, range 1..8.
REQ-002 SHALL have parameter PRESCALE, default 50000000: clkIn cycles per count tick, minimum 2.
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap at terminal count, 0 = stop at terminal count.
REQ-004 SHALL have port clkIn, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-low.
REQ-006 SHALL have port en, input, 1: run enable, level.
REQ-007 SHALL have port up_dn, input, 1: 1 = count up, 0 = count down.
REQ-008 SHALL have port clr, input, 1: synchronous clear, level.
REQ-009 SHALL have port load, input, 1: synchronous load strobe.
REQ-010 SHALL have port load_val, input, 4*DIGITS: BCD preset value, digit 0 in bits [3:0].
REQ-011 SHALL have port bcd, output, 4*DIGITS: registered BCD count, digit 0 (LSD) in bits [3:0].
REQ-012 SHALL have port seg, output, 7*DIGITS: seven-segment patterns, digit i in bits [7i+6:7i], bit 7i = a through bit 7i+6 = g, 1 = lit.
REQ-013 SHALL have port indicator, output, 1: tick-rate blink LED.
REQ-014 SHALL have port tc, output, 1: terminal-count pulse.
REQ-015 SHALL have port done, output, 1: high while stopped at terminal count.

Function
REQ-016 SHALL implement states STOP, RUN and DONE, with RUN entered from STOP when en=1 and STOP entered from RUN when en=0.
REQ-017 SHALL advance the prescaler by 1 per clkIn only in RUN, wrap it at PRESCALE-1 and assert an internal tick in that cycle.
REQ-018 SHALL hold the prescaler in STOP (pause and resume without loss) and force it to 0 on clr, load or entry to DONE.
REQ-019 SHALL update bcd on each tick, one cycle after the tick, as a ripple-carry BCD count: up 9->0 with carry, down 0->9 with borrow.
REQ-020 SHALL, with WRAP=1, roll over all-9s to all-0s (up) and all-0s to all-9s (down), pulsing tc for one cycle with that update.
REQ-021 SHALL, with WRAP=0, on a tick at all-9s (up) or all-0s (down), hold bcd, pulse tc for one cycle, enter DONE and assert done.
REQ-022 SHALL leave DONE only on clr, on load, or on a change of up_dn that makes the count non-terminal, entering STOP in each case.
REQ-023 SHALL apply clr (bcd to 0) with priority over load, and load over tick; clr or load during a tick cycle suppresses that tick and tc.
REQ-024 SHALL saturate any load_val digit greater than 9 to 9 on load.
REQ-025 SHALL sample up_dn at each tick, so a change applies at the next tick and does not reset the prescaler.
REQ-026 SHALL derive seg combinationally from bcd, encoding 0..9 as a,b,c,d,e,f,g: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011.
REQ-027 SHALL drive indicator high while in RUN with prescaler below PRESCALE/2 (integer division), and low otherwise.
REQ-028 SHALL support DIGITS=1, in which case the terminal values are 9 and 0.

Reset
REQ-029 SHALL, while rst=0 and independent of clkIn, force state STOP, prescaler 0, bcd 0, tc 0, done 0 and indicator 0, so that seg shows 1111110 on every digit.
REQ-030 SHALL discard a count in progress when rst is asserted mid-RUN and restart from 0 in STOP after release, entering RUN on the first clkIn with en=1.

Verification (DIGITS=2, PRESCALE=4)
REQ-031 SHALL test: reset release, then en=1 for 40 cycles -> bcd 0x10, indicator high 2 of every 4 cycles, tc never asserted.
REQ-032 SHALL test, with WRAP=1: load 0x98, up -> bcd goes 0x99 then 0x00, with a one-cycle tc on the 0x00 update; seg[6:0]=1111110.
REQ-033 SHALL test, with WRAP=0: load 0x01, down -> bcd goes 0x00, tc pulses, done=1; further ticks leave bcd at 0x00; up_dn=1 -> STOP, done=0.
REQ-034 SHALL test: load with load_val=0xFA -> bcd 0x99, and clr asserted together with load -> bcd 0x00.
REQ-035 SHALL test: en dropped for 10 cycles mid-period at prescaler=2 -> bcd frozen, and the next tick occurs 2 cycles after en returns.
REQ-036 SHALL test: rst pulsed low between clkIn edges at bcd 0x57 -> all outputs cleared immediately, with no clock edge required.

Source files
------------

// File: rtl/counter_7seg_param.sv
// Up/down BCD counter with prescaled tick, wrap/stop at terminal count and
// per-digit seven-segment decode.
//   state | meaning
//   STOP  | paused, prescaler held
//   RUN   | prescaler advancing, bcd steps on each tick
//   DONE  | halted at terminal count (WRAP=0 only)
module counter_7seg_param #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50000000,
  parameter int WRAP     = 1
) (
  input  logic                clkIn,
  input  logic                rst,
  input  logic                en,
  input  logic                up_dn,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                indicator,
  output logic                tc,
  output logic                done
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PSC_HALF = PW'(PRESCALE / 2);

  typedef enum logic [1:0] {STOP, RUN, DONE} state_t;

  state_t              state, state_n;
  logic [PW-1:0]       psc, psc_n;
  logic [4*DIGITS-1:0] bcd_n, bcd_step, bcd_sat;
  logic                tc_n;
  logic                all9, all0, term, tick, tick_eff;

  // Ripple-carry step in the current direction plus terminal detect and load saturation
  always_comb begin
    logic       carry;
    logic [3:0] d;
    bcd_step = bcd;
    bcd_sat  = '0;
    carry    = 1'b1;
    all9     = 1'b1;
    all0     = 1'b1;
    d        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd[4*i +: 4];
      if (d != 4'd9) all9 = 1'b0;
      if (d != 4'd0) all0 = 1'b0;
      if (carry) begin
        if (up_dn) begin
          bcd_step[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
          carry = (d == 4'd9);
        end else begin
          bcd_step[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
          carry = (d == 4'd0);
        end
      end
      bcd_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  assign term     = up_dn ? all9 : all0;
  assign tick     = (state == RUN) && en && (psc == PSC_LAST);
  assign tick_eff = tick && !clr && !load;

  always_comb begin
    state_n = state;
    psc_n   = psc;
    bcd_n   = bcd;
    tc_n    = 1'b0;
    if (state == RUN && en) psc_n = (psc == PSC_LAST) ? '0 : psc + PW'(1);
    case (state)
      STOP: if (en) state_n = RUN;
      RUN: begin
        if (!en) begin
          state_n = STOP;
        end else if (tick_eff && term && (WRAP == 0)) begin
          state_n = DONE;
          psc_n   = '0;
        end
      end
      DONE: if (clr || load || !term) state_n = STOP;
      default: state_n = STOP;
    endcase
    if (clr) begin
      bcd_n = '0;
      psc_n = '0;
    end else if (load) begin
      bcd_n = bcd_sat;
      psc_n = '0;
    end else if (tick_eff) begin
      tc_n = term;
      if (!(term && (WRAP == 0))) bcd_n = bcd_step;
    end
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      state <= STOP;
      psc   <= '0;
      bcd   <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      psc   <= psc_n;
      bcd   <= bcd_n;
      tc    <= tc_n;
    end
  end

  assign done      = (state == DONE);
  assign indicator = (state == RUN) && (psc < PSC_HALF);

  // Segment bit 0 is 'a', bit 6 is 'g'
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg[7*g +: 7] = seg_of(bcd[4*g +: 4]);
  end

endmodule

// File: tb/tb_counter_7seg_param.sv
// Bench for counter_7seg_param: a wrapping and a stopping instance, bcd/tc
// updates scored against queues of expected events.
module tb_counter_7seg_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_w = 1'b0, en_s = 1'b0;
  logic       up_dn = 1'b1, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0]  bcd_w, bcd_s;
  logic [13:0] seg_w, seg_s;
  logic        ind_w, ind_s, tc_w, tc_s, done_w, done_s;

  typedef struct packed {
    logic [7:0] bcd;
    logic       tc;
  } ev_t;

  ev_t  q_w[$];
  ev_t  q_s[$];
  logic mon_w = 1'b0, mon_s = 1'b0;
  logic [7:0] prev_w = 8'h00, prev_s = 8'h00;
  int   errors = 0;
  int   checks = 0;

  localparam logic [6:0] SEG_AG [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
    7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  counter_7seg_param #(.DIGITS(2), .PRESCALE(4), .WRAP(1)) u_w (
    .clkIn(clk), .rst(rst), .en(en_w), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .bcd(bcd_w), .seg(seg_w), .indicator(ind_w), .tc(tc_w), .done(done_w));

  counter_7seg_param #(.DIGITS(2), .PRESCALE(4), .WRAP(0)) u_s (
    .clkIn(clk), .rst(rst), .en(en_s), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .bcd(bcd_s), .seg(seg_s), .indicator(ind_s), .tc(tc_s), .done(done_s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] p, r;
    p = SEG_AG[d];
    for (int i = 0; i < 7; i++) r[i] = p[6-i];
    return r;
  endfunction

  task automatic exp_w(input logic [7:0] b, input logic t);
    q_w.push_back('{bcd: b, tc: t});
  endtask

  task automatic exp_s(input logic [7:0] b, input logic t);
    q_s.push_back('{bcd: b, tc: t});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input bit sel, input string tag, input int budget);
    int n = 0;
    while (n < budget && (sel ? q_s.size() : q_w.size()) != 0) begin
      step();
      n++;
    end
    chk(tag, sel ? q_s.size() : q_w.size(), 0);
  endtask

  // Any bcd change or tc pulse must match the next queued expectation
  always @(negedge clk) begin
    if (mon_w && (bcd_w !== prev_w || tc_w !== 1'b0)) begin
      if (q_w.size() == 0) chk("w_unexpected_event", 32'(q_w.size()), 32'd1);
      else begin
        chk("w_bcd", bcd_w, q_w[0].bcd);
        chk("w_tc", tc_w, q_w[0].tc);
        void'(q_w.pop_front());
      end
    end
    if (mon_s && (bcd_s !== prev_s || tc_s !== 1'b0)) begin
      if (q_s.size() == 0) chk("s_unexpected_event", 32'(q_s.size()), 32'd1);
      else begin
        chk("s_bcd", bcd_s, q_s[0].bcd);
        chk("s_tc", tc_s, q_s[0].tc);
        void'(q_s.pop_front());
      end
    end
    prev_w <= bcd_w;
    prev_s <= bcd_s;
  end

  initial begin
    int hi;
    logic [3:0] dv;
    #1 rst = 1'b0;
    #2;
    chk("rst_bcd", bcd_w, 8'h00);
    chk("rst_seg", seg_w, {seg_ref(0), seg_ref(0)});
    chk("rst_ind", ind_w, 1'b0);
    chk("rst_tc", tc_w, 1'b0);
    chk("rst_done", done_s, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    chk("stop_ind", ind_w, 1'b0);
    mon_w = 1'b1;

    // Free run from reset: ten ticks in 40 run cycles, 50% indicator duty
    for (int v = 1; v <= 10; v++) exp_w(8'((v / 10) * 16 + (v % 10)), 1'b0);
    en_w = 1'b1;
    hi = 0;
    repeat (40) begin
      step();
      if (ind_w) hi++;
    end
    chk("ind_duty", hi, 20);
    drain(1'b0, "run40_drain", 10);
    chk("run40_bcd", bcd_w, 8'h10);

    // Wrap 98 -> 99 -> 00 with a single tc
    en_w = 1'b0;
    load_val = 8'h98;
    load = 1'b1;
    exp_w(8'h98, 1'b0);
    step();
    load = 1'b0;
    en_w = 1'b1;
    exp_w(8'h99, 1'b0);
    exp_w(8'h00, 1'b1);
    drain(1'b0, "wrap_drain", 20);
    chk("wrap_seg", seg_w[6:0], seg_ref(0));
    en_w = 1'b0;
    step();
    chk("wrap_tc_one_cycle", tc_w, 1'b0);

    // Load saturation, then clr beating load
    load_val = 8'hFA;
    load = 1'b1;
    exp_w(8'h99, 1'b0);
    step();
    chk("sat_bcd", bcd_w, 8'h99);
    chk("sat_seg", seg_w, {seg_ref(9), seg_ref(9)});
    load_val = 8'h12;
    clr = 1'b1;
    exp_w(8'h00, 1'b0);
    step();
    clr = 1'b0;
    chk("clr_over_load", bcd_w, 8'h00);

    // Segment decode sweep through every digit value
    for (int d = 1; d <= 10; d++) begin
      dv = 4'(d % 10);
      load_val = {dv, dv};
      exp_w({dv, dv}, 1'b0);
      step();
      chk("seg_sweep", seg_w, {seg_ref(d % 10), seg_ref(d % 10)});
    end
    load = 1'b0;

    // Pause at prescaler 2 and resume without losing phase
    en_w = 1'b1;
    exp_w(8'h01, 1'b0);
    step();
    chk("ind_psc0", ind_w, 1'b1);
    step(); step();
    chk("ind_psc2", ind_w, 1'b0);
    en_w = 1'b0;
    repeat (10) step();
    chk("pause_frozen", bcd_w, 8'h00);
    en_w = 1'b1;
    step();
    chk("resume_c1", bcd_w, 8'h00);
    step();
    chk("resume_c2", bcd_w, 8'h00);
    step();
    chk("resume_tick", bcd_w, 8'h01);
    drain(1'b0, "pause_drain", 2);
    en_w = 1'b0;
    step();
    mon_w = 1'b0;

    // Stop-at-terminal instance: 01 -> 00 -> tc, DONE, then direction change releases
    mon_s = 1'b1;
    up_dn = 1'b0;
    load_val = 8'h01;
    load = 1'b1;
    exp_s(8'h01, 1'b0);
    step();
    load = 1'b0;
    en_s = 1'b1;
    exp_s(8'h00, 1'b0);
    exp_s(8'h00, 1'b1);
    drain(1'b1, "stop_drain", 20);
    chk("stop_done", done_s, 1'b1);
    step();
    chk("stop_tc_one_cycle", tc_s, 1'b0);
    repeat (12) step();
    chk("stop_hold_bcd", bcd_s, 8'h00);
    chk("stop_hold_done", done_s, 1'b1);
    up_dn = 1'b1;
    step();
    chk("stop_release", done_s, 1'b0);
    en_s = 1'b0;
    step();
    mon_s = 1'b0;

    // Asynchronous reset mid-run at 57, then restart into RUN
    mon_w = 1'b1;
    load_val = 8'h57;
    load = 1'b1;
    exp_w(8'h57, 1'b0);
    step();
    load = 1'b0;
    en_w = 1'b1;
    step();
    @(posedge clk);
    #2;
    chk("pre_rst_ind", ind_w, 1'b1);
    exp_w(8'h00, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_bcd", bcd_w, 8'h00);
    chk("async_seg", seg_w, {seg_ref(0), seg_ref(0)});
    chk("async_ind", ind_w, 1'b0);
    chk("async_tc", tc_w, 1'b0);
    chk("async_done", done_w, 1'b0);
    chk("async_bcd_s", bcd_s, 8'h00);
    step(); step();
    rst = 1'b1;
    step();
    chk("restart_run", ind_w, 1'b1);
    chk("restart_bcd", bcd_w, 8'h00);
    exp_w(8'h01, 1'b0);
    drain(1'b0, "restart_drain", 8);
    en_w = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
